// File: rtl/pzx_recorder.sv
// Tape/EAR pulse recorder: times level changes in Z80 T-states and streams them into SRAM
// as PZX PULS-style duration words (2 bytes short, 4 bytes long).
module pzx_recorder #(
    parameter int unsigned TSTATE_DIV = 8,
    parameter logic [20:0] BASE_ADDR  = 21'h000000,
    parameter logic [20:0] LIMIT_ADDR = 21'h1FFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ear_in,
    input  logic        rec,
    input  logic        stop,
    output logic [20:0] sramaddr,
    output logic [7:0]  sramdata_out,
    output logic        sramdata_oe,
    output logic        sramwe_n,
    output logic        recording,
    output logic        full,
    output logic        overrun,
    output logic [20:0] length
);

    localparam int unsigned   PW        = (TSTATE_DIV > 1) ? $clog2(TSTATE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TSTATE_DIV - 1);
    localparam logic [30:0]   DUR_MAX   = 31'h7FFF_FFFF;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StArm     = 2'd1;
    localparam logic [1:0] StMeasure = 2'd2;
    localparam logic [1:0] StFlush   = 2'd3;

    logic          ear_s1_q, ear_s1_d, ear_s2_q, ear_s2_d, ear_prev_q, ear_prev_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [30:0]   dur_q, dur_d;
    logic [1:0]    state_q, state_d;
    logic [30:0]   hold_q, hold_d;
    logic          pend_q, pend_d;
    logic          busy_q, busy_d;
    logic [1:0]    ph_q, ph_d;
    logic [1:0]    left_q, left_d;
    logic [31:0]   sh_q, sh_d;
    logic [20:0]   addr_q, addr_d;
    logic [20:0]   len_q, len_d;
    logic          full_q, full_d;
    logic          overrun_q, overrun_d;

    logic        tick, ear_edge, word_long, word_fits, drop;
    logic [30:0] dur_inc;
    logic [31:0] word_bytes;

    assign tick     = (presc_q == PRESC_MAX);
    assign ear_edge = ear_s2_q ^ ear_prev_q;
    // Count the tick landing on the edge clk so an interval of N*TSTATE_DIV clk reads exactly N.
    assign dur_inc  = (tick && (dur_q != DUR_MAX)) ? dur_q + 31'd1 : dur_q;

    assign word_long  = |hold_q[30:15];
    assign word_fits  = ({1'b0, addr_q} + (word_long ? 22'd3 : 22'd1)) <= {1'b0, LIMIT_ADDR};
    // Byte order as emitted, least significant byte first.
    assign word_bytes = word_long
        ? {hold_q[15:8], hold_q[7:0], 1'b1, hold_q[30:24], hold_q[23:16]}
        : {16'h0000, hold_q[15:8], hold_q[7:0]};

    always_comb begin
        ear_s1_d   = ear_in;
        ear_s2_d   = ear_s1_q;
        ear_prev_d = ear_s2_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;
        dur_d      = ear_edge ? '0 : dur_inc;
        state_d    = state_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        busy_d     = busy_q;
        ph_d       = ph_q;
        left_d     = left_q;
        sh_d       = sh_q;
        addr_d     = addr_q;
        len_d      = len_q;
        full_d     = full_q;
        overrun_d  = overrun_q;
        drop       = 1'b0;

        // Writer: C0 setup, C1 strobe, C2 hold, then advance.
        if (busy_q) begin
            case (ph_q)
                2'd0:    ph_d = 2'd1;
                2'd1:    ph_d = 2'd2;
                default: begin
                    ph_d   = 2'd0;
                    addr_d = addr_q + 21'd1;
                    len_d  = len_q + 21'd1;
                    if (left_q == 2'd0) begin
                        busy_d = 1'b0;
                    end else begin
                        left_d = left_q - 2'd1;
                        sh_d   = sh_q >> 8;
                    end
                end
            endcase
        end else if (pend_q) begin
            pend_d = 1'b0;
            if (word_fits) begin
                busy_d = 1'b1;
                ph_d   = 2'd0;
                left_d = word_long ? 2'd3 : 2'd1;
                sh_d   = word_bytes;
            end else begin
                full_d = 1'b1;
                drop   = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (rec && !stop) begin
                    state_d   = StArm;
                    full_d    = 1'b0;
                    overrun_d = 1'b0;
                    len_d     = '0;
                    addr_d    = BASE_ADDR;
                end
            end
            StArm: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (ear_edge) begin
                    state_d = StMeasure;
                    // The stream implicitly starts low, so a high first level needs a zero pulse.
                    if (ear_s2_q) begin
                        hold_d = '0;
                        pend_d = 1'b1;
                    end
                end
            end
            StMeasure: begin
                if (stop) begin
                    hold_d  = dur_inc;
                    pend_d  = 1'b1;
                    state_d = StFlush;
                end else if (ear_edge) begin
                    hold_d = dur_inc;
                    pend_d = 1'b1;
                    if (busy_q) overrun_d = 1'b1;
                end
            end
            default: begin
                if (!pend_q && !busy_q) state_d = StIdle;
            end
        endcase

        if (drop) begin
            state_d = StIdle;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ear_s1_q   <= 1'b0;
            ear_s2_q   <= 1'b0;
            ear_prev_q <= 1'b0;
            presc_q    <= '0;
            dur_q      <= '0;
            state_q    <= StIdle;
            hold_q     <= '0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            ph_q       <= 2'd0;
            left_q     <= 2'd0;
            sh_q       <= '0;
            addr_q     <= BASE_ADDR;
            len_q      <= '0;
            full_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            ear_s1_q   <= ear_s1_d;
            ear_s2_q   <= ear_s2_d;
            ear_prev_q <= ear_prev_d;
            presc_q    <= presc_d;
            dur_q      <= dur_d;
            state_q    <= state_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            ph_q       <= ph_d;
            left_q     <= left_d;
            sh_q       <= sh_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            full_q     <= full_d;
            overrun_q  <= overrun_d;
        end
    end

    assign sramaddr     = addr_q;
    assign sramdata_out = sh_q[7:0];
    assign sramdata_oe  = busy_q;
    assign sramwe_n     = ~(busy_q && (ph_q == 2'd1));
    assign recording    = (state_q != StIdle);
    assign full         = full_q;
    assign overrun      = overrun_q;
    assign length       = len_q;

endmodule

// File: tb/tb_pzx_recorder.sv
// Scoreboard bench for pzx_recorder: directed ear_in waveforms push expected SRAM writes,
// per-instance monitors pop and compare on every write strobe.
module tb_pzx_recorder;

    typedef struct packed {
        logic [20:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        a_ear = 1'b0, a_rec = 1'b0, a_stop = 1'b0;
    logic        b_ear = 1'b0, b_rec = 1'b0, b_stop = 1'b0;
    logic [20:0] a_addr, b_addr, a_len, b_len;
    logic [7:0]  a_data, b_data;
    logic        a_oe, a_we_n, a_recording, a_full, a_overrun;
    logic        b_oe, b_we_n, b_recording, b_full, b_overrun;

    int checks = 0;
    int failures = 0;
    wr_t q_a[$];
    wr_t q_b[$];
    bit  a_prev_low = 1'b0;
    bit  b_prev_low = 1'b0;

    pzx_recorder #(.TSTATE_DIV(1)) u_dut_a (
        .clk(clk), .rst(rst), .ear_in(a_ear), .rec(a_rec), .stop(a_stop),
        .sramaddr(a_addr), .sramdata_out(a_data), .sramdata_oe(a_oe), .sramwe_n(a_we_n),
        .recording(a_recording), .full(a_full), .overrun(a_overrun), .length(a_len)
    );

    pzx_recorder #(.TSTATE_DIV(8), .BASE_ADDR(21'h000100), .LIMIT_ADDR(21'h000104)) u_dut_b (
        .clk(clk), .rst(rst), .ear_in(b_ear), .rec(b_rec), .stop(b_stop),
        .sramaddr(b_addr), .sramdata_out(b_data), .sramdata_oe(b_oe), .sramwe_n(b_we_n),
        .recording(b_recording), .full(b_full), .overrun(b_overrun), .length(b_len)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input bit sel, input logic [20:0] addr, input logic [7:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        if (sel) q_b.push_back(w);
        else     q_a.push_back(w);
    endtask

    task automatic wait_idle(input bit sel, input int budget);
        int n = 0;
        while (((sel ? b_recording : a_recording) === 1'b1) && n < budget) begin
            cyc(1);
            n++;
        end
        chk(sel ? "b_idle_timeout" : "a_idle_timeout", 32'(sel ? b_recording : a_recording), 0);
    endtask

    task automatic wait_drain(input bit sel, input int budget);
        int n = 0;
        while ((sel ? q_b.size() : q_a.size()) != 0 && n < budget) begin
            cyc(1);
            n++;
        end
        chk(sel ? "b_drain" : "a_drain", 32'(sel ? q_b.size() : q_a.size()), 0);
    endtask

    // Monitors: every strobe must match the head of the queue and last exactly one clk.
    always @(negedge clk) begin
        wr_t e;
        if (a_we_n === 1'b0) begin
            chk("a_we_width", 32'(a_prev_low), 0);
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_write: addr %0h data %0h, none expected", a_addr, a_data);
            end else begin
                e = q_a.pop_front();
                chk("a_wr_addr", 32'(a_addr), 32'(e.addr));
                chk("a_wr_data", 32'(a_data), 32'(e.data));
                chk("a_wr_oe", 32'(a_oe), 1);
            end
        end
        a_prev_low = (a_we_n === 1'b0);
    end

    always @(negedge clk) begin
        wr_t e;
        if (b_we_n === 1'b0) begin
            chk("b_we_width", 32'(b_prev_low), 0);
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_write: addr %0h data %0h, none expected", b_addr, b_data);
            end else begin
                e = q_b.pop_front();
                chk("b_wr_addr", 32'(b_addr), 32'(e.addr));
                chk("b_wr_data", 32'(b_data), 32'(e.data));
                chk("b_wr_oe", 32'(b_oe), 1);
            end
        end
        b_prev_low = (b_we_n === 1'b0);
    end

    initial begin
        int n;
        // Reset state
        cyc(3);
        chk("rst_addr", 32'(a_addr), 0);
        chk("rst_data", 32'(a_data), 0);
        chk("rst_oe", 32'(a_oe), 0);
        chk("rst_we_n", 32'(a_we_n), 1);
        chk("rst_recording", 32'(a_recording), 0);
        chk("rst_flags", {30'd0, a_full, a_overrun}, 0);
        chk("rst_length", 32'(a_len), 0);
        chk("rst_b_addr", 32'(b_addr), 32'h100);
        rst = 1'b0;
        cyc(2);

        // Rising first edge: zero word, then 2168 high, then 100 low flushed by stop
        push(0, 21'd0, 8'h00); push(0, 21'd1, 8'h00);
        push(0, 21'd2, 8'h78); push(0, 21'd3, 8'h08);
        push(0, 21'd4, 8'h64); push(0, 21'd5, 8'h00);
        a_rec = 1'b1; cyc(1); a_rec = 1'b0;
        chk("s1_recording", 32'(a_recording), 1);
        a_ear = 1'b1; cyc(2168);
        a_ear = 1'b0; cyc(102);
        a_stop = 1'b1; cyc(1); a_stop = 1'b0;
        wait_idle(0, 100);
        wait_drain(0, 100);
        chk("s1_length", 32'(a_len), 6);
        chk("s1_addr", 32'(a_addr), 6);
        chk("s1_flags", {30'd0, a_full, a_overrun}, 0);

        // Falling first edge: no zero word; rec mid-measure is ignored
        a_ear = 1'b1; cyc(5);
        push(0, 21'd0, 8'h9B); push(0, 21'd1, 8'h02);
        push(0, 21'd2, 8'h32); push(0, 21'd3, 8'h00);
        a_rec = 1'b1; cyc(1); a_rec = 1'b0;
        chk("s2_length_clr", 32'(a_len), 0);
        chk("s2_addr_base", 32'(a_addr), 0);
        a_ear = 1'b0; cyc(300);
        a_rec = 1'b1; cyc(1); a_rec = 1'b0;
        cyc(366);
        a_ear = 1'b1; cyc(52);
        a_stop = 1'b1; cyc(1); a_stop = 1'b0;
        wait_idle(0, 100);
        wait_drain(0, 100);
        chk("s2_length", 32'(a_len), 4);

        // Long word 0x8123, then edges 2T and 1T later while it is in flight
        a_ear = 1'b0; cyc(5);
        push(0, 21'd0, 8'h00); push(0, 21'd1, 8'h00);
        push(0, 21'd2, 8'h00); push(0, 21'd3, 8'h80);
        push(0, 21'd4, 8'h23); push(0, 21'd5, 8'h81);
        push(0, 21'd6, 8'h01); push(0, 21'd7, 8'h00);
        push(0, 21'd8, 8'h28); push(0, 21'd9, 8'h00);
        a_rec = 1'b1; cyc(1); a_rec = 1'b0;
        a_ear = 1'b1; cyc(33059);
        a_ear = 1'b0; cyc(2);
        a_ear = 1'b1; cyc(1);
        a_ear = 1'b0; cyc(42);
        a_stop = 1'b1; cyc(1); a_stop = 1'b0;
        wait_idle(0, 100);
        wait_drain(0, 100);
        chk("s3_overrun", 32'(a_overrun), 1);
        chk("s3_full", 32'(a_full), 0);
        chk("s3_length", 32'(a_len), 10);
        chk("s3_addr", 32'(a_addr), 10);

        // rec+stop together: stop wins, so flags from before survive
        a_rec = 1'b1; a_stop = 1'b1; cyc(1); a_rec = 1'b0; a_stop = 1'b0;
        chk("s4_recstop_idle", 32'(a_recording), 0);
        chk("s4_recstop_overrun", 32'(a_overrun), 1);
        // stop in ARM: back to IDLE, nothing written
        a_rec = 1'b1; cyc(1); a_rec = 1'b0;
        chk("s4_arm", 32'(a_recording), 1);
        chk("s4_arm_overrun_clr", 32'(a_overrun), 0);
        cyc(3);
        a_stop = 1'b1; cyc(1); a_stop = 1'b0;
        chk("s4_stop_arm", 32'(a_recording), 0);
        cyc(20);
        chk("s4_length", 32'(a_len), 0);

        // Limit at BASE+4 with TSTATE_DIV=8: third 2-byte word does not fit
        b_ear = 1'b1; cyc(5);
        push(1, 21'h100, 8'h0A); push(1, 21'h101, 8'h00);
        push(1, 21'h102, 8'h14); push(1, 21'h103, 8'h00);
        b_rec = 1'b1; cyc(1); b_rec = 1'b0;
        b_ear = 1'b0; cyc(80);
        b_ear = 1'b1; cyc(160);
        b_ear = 1'b0; cyc(240);
        b_ear = 1'b1;
        wait_idle(1, 60);
        wait_drain(1, 60);
        chk("s6_full", 32'(b_full), 1);
        chk("s6_length", 32'(b_len), 4);
        chk("s6_addr", 32'(b_addr), 32'h104);

        // Reset in the middle of a strobe
        push(0, 21'd0, 8'h00);
        a_rec = 1'b1; cyc(1); a_rec = 1'b0;
        a_ear = 1'b1;
        n = 0;
        while (a_we_n !== 1'b0 && n < 40) begin
            cyc(1);
            n++;
        end
        chk("s5_we_seen", 32'(a_we_n), 0);
        rst = 1'b1; cyc(1);
        chk("s5_we_n", 32'(a_we_n), 1);
        chk("s5_oe", 32'(a_oe), 0);
        chk("s5_recording", 32'(a_recording), 0);
        chk("s5_addr", 32'(a_addr), 0);
        chk("s5_b_flags", {30'd0, b_full, b_overrun}, 0);
        chk("s5_b_length", 32'(b_len), 0);
        chk("s5_b_addr", 32'(b_addr), 32'h100);
        rst = 1'b0;
        cyc(10);
        chk("a_queue_empty", 32'(q_a.size()), 0);
        chk("b_queue_empty", 32'(q_b.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
